// File: rtl/bin2bcd_ctrl_if.sv
// bin2bcd_ctrl_if -- request/result bundle of the binary-to-BCD converter.
//   start  producer -> converter  conversion request (sampled while idle)
//   bin    producer -> converter  8-bit binary operand
//   busy   converter -> producer  conversion in progress
//   done   converter -> producer  one-cycle pulse, bcd/blank just updated
//   bcd    converter -> producer  packed hundreds/tens/units digits
//   blank  converter -> producer  leading-zero mask, [2] hundreds .. [0] units
// Modports: master = producer side, slave = converter side.
interface bin2bcd_ctrl_if;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [2:0]  blank;

    modport master (output start, bin, input  busy, done, bcd, blank);
    modport slave  (input  start, bin, output busy, done, bcd, blank);
endinterface

// File: rtl/bin2bcd_ctrl.sv
// bin2bcd_ctrl -- sequential 8-bit binary to 3-digit BCD converter.
// One shift-add-3 step (adjust_shift) is applied per clock for 8 clocks after
// a start is accepted; the packed result is then published with a done pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    bin2bcd_ctrl_if.slave (start, bin, busy, done, bcd, blank)
// Build option: define BIN2BCD_BLANK_EN to register a leading-zero mask on
// blank at completion; otherwise blank stays 3'b000.

// adjust_shift -- one double-dabble step on a 20-bit word:
// every BCD nibble [19:8] above 4 gets +3, then the word shifts left by one.
//   i_work  working word before the step
//   o_work  working word after the step
module adjust_shift (
    input  logic [19:0] i_work,
    output logic [19:0] o_work
);
    logic [19:0] w_adj;

    always_comb begin
        w_adj = i_work;
        if (i_work[19:16] > 4'd4) w_adj[19:16] = i_work[19:16] + 4'd3;
        if (i_work[15:12] > 4'd4) w_adj[15:12] = i_work[15:12] + 4'd3;
        if (i_work[11:8]  > 4'd4) w_adj[11:8]  = i_work[11:8]  + 4'd3;
        o_work = {w_adj[18:0], 1'b0};
    end
endmodule

module bin2bcd_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    bin2bcd_ctrl_if.slave  bus
);
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      r_state;
    logic [19:0] r_work;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [11:0] r_bcd;
    logic [2:0]  r_blank;

    logic [19:0] w_step;
    logic [2:0]  w_blank;

    adjust_shift u_step (
        .i_work (r_work),
        .o_work (w_step)
    );

    // Mask is derived from the final step result so it lands together with bcd.
`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        w_blank    = '0;
        w_blank[2] = (w_step[19:16] == 4'd0);
        w_blank[1] = (w_step[19:16] == 4'd0) && (w_step[15:12] == 4'd0);
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_blank <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_work  <= {12'd0, bus.bin};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_bcd   <= w_step[19:8];
                        r_blank <= w_blank;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.bcd   = r_bcd;
    assign bus.blank = r_blank;
endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// tb_bin2bcd_ctrl -- self-checking bench for bin2bcd_ctrl.
// Expected digits come from plain decimal arithmetic on the operand; the
// leading-zero mask follows BIN2BCD_BLANK_EN the same way the design does.
module tb_bin2bcd_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    bin2bcd_ctrl_if bus ();

    bin2bcd_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] exp_bcd(input int v);
        exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] exp_blank(input int v);
`ifdef BIN2BCD_BLANK_EN
        exp_blank = {v < 100, v < 10, 1'b0};
`else
        exp_blank = 3'b000;
`endif
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a conversion from an idle point and wait (bounded) for done.
    // lat counts edges from the accepting edge to the edge raising done.
    task automatic launch_and_wait(input logic [7:0] v, output int lat, output bit busy_ok);
        bus.start = 1'b1;
        bus.bin   = v;
        tick();
        busy_ok   = bus.busy && !bus.done;
        bus.start = 1'b0;
        bus.bin   = 8'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            lat = k;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic convert(input logic [7:0] v, input string tag);
        int lat;
        bit busy_ok;
        launch_and_wait(v, lat, busy_ok);
        check({tag, "_latency"}, 32'(lat), 32'(8));
        check({tag, "_busy_during"}, 32'(busy_ok), 32'(1));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'(0));
        check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd(int'(v))));
        check({tag, "_blank"}, 32'(bus.blank), 32'(exp_blank(int'(v))));
        tick();
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'(0));
        check({tag, "_bcd_hold"}, 32'(bus.bcd), 32'(exp_bcd(int'(v))));
    endtask

    initial begin
        int  lat;
        int  dones;
        bit  busy_ok;
        bit  sweep_ok;
        bit  nib_ok;
        logic [7:0] v;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = 8'd0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_bcd", 32'(bus.bcd), 32'(0));
        check("rst_blank", 32'(bus.blank), 32'(0));
        rst_n = 1'b1;
        tick();

        convert(8'd255, "max");
        convert(8'd0, "zero");
        convert(8'd9, "nine");

        // Back-to-back: start held through the done cycle with a new operand.
        launch_and_wait(8'd99, lat, busy_ok);
        check("b2b_first_latency", 32'(lat), 32'(8));
        check("b2b_first_bcd", 32'(bus.bcd), 32'(12'h099));
        check("b2b_first_blank", 32'(bus.blank), 32'(exp_blank(99)));
        bus.start = 1'b1;
        bus.bin   = 8'd100;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            lat = k;
            bus.start = 1'b0;
            if (bus.done) break;
        end
        check("b2b_second_spacing", 32'(lat), 32'(9));
        check("b2b_second_bcd", 32'(bus.bcd), 32'(12'h100));
        check("b2b_second_blank", 32'(bus.blank), 32'(exp_blank(100)));
        tick();

        // Start during SHIFT is ignored and not queued.
        bus.start = 1'b1;
        bus.bin   = 8'd128;
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                bus.start = 1'b1;
                bus.bin   = 8'd7;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done) begin
                dones++;
                check("ignore_latency", 32'(k), 32'(8));
                check("ignore_bcd", 32'(bus.bcd), 32'(12'h128));
            end
        end
        check("ignore_done_count", 32'(dones), 32'(1));
        check("ignore_idle_after", 32'(bus.busy), 32'(0));

        // Reset mid-conversion of 200, then reset together with start.
        bus.start = 1'b1;
        bus.bin   = 8'd200;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_bcd", 32'(bus.bcd), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        bus.start = 1'b1;
        bus.bin   = 8'd55;
        tick();
        check("rst_start_busy", 32'(bus.busy), 32'(0));
        bus.start = 1'b0;
        rst_n     = 1'b1;
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        check("abort_no_activity", 32'(dones), 32'(0));
        check("abort_bcd_after", 32'(bus.bcd), 32'(0));

        // Random operands.
        for (int n = 0; n < 24; n++) begin
            v = 8'($urandom_range(255, 0));
            convert(v, "rand");
        end

        // Exhaustive sweep, folded into a few checks.
        sweep_ok = 1'b1;
        nib_ok   = 1'b1;
        for (int unsigned i = 0; i < 256; i++) begin
            launch_and_wait(8'(i), lat, busy_ok);
            if (lat != 8 || !busy_ok || bus.bcd !== exp_bcd(int'(i)) ||
                bus.blank !== exp_blank(int'(i))) begin
                sweep_ok = 1'b0;
                $display("FAIL sweep_%0d: got bcd %0h lat %0d, expected %0h lat 8",
                         i, bus.bcd, lat, exp_bcd(int'(i)));
            end
            if (bus.bcd[11:8] > 4'd9 || bus.bcd[7:4] > 4'd9 || bus.bcd[3:0] > 4'd9)
                nib_ok = 1'b0;
            if (i % 3 == 0) tick();
        end
        check("sweep_all", 32'(sweep_ok), 32'(1));
        check("sweep_nibbles", 32'(nib_ok), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bin2bcd_ctrl.md
# bin2bcd_ctrl

Sequential 8-bit binary to 3-digit BCD converter built around the existing shift-add-3 step (`adjust_shift`). It owns the 20-bit working register and the step counter, and accepts a start request. It then applies the combinational step once per clock for 8 clocks and publishes the packed BCD result with a one-cycle done pulse. It sits between binary producers (counters, ADC samples) and the 7-segment display drivers in the demo designs.

## Interface
- Parameters: none. Widths are fixed at 8-bit binary in and 3 BCD digits out.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  conversion request; sampled only while `busy`=0.
- `bin`  in  8  binary operand; captured in the same cycle `start` is accepted.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bcd` has just been updated.
- `bcd`  out  12  result, packed as [11:8] hundreds, [7:4] tens, [3:0] units; holds until the next completion.
- `blank`  out  3  leading-zero mask, one bit per digit, [2] hundreds … [0] units; see Configuration.

## Operation
- Working register `work[19:0]`: [19:8] BCD digits, [7:0] remaining binary bits. Step counter `cnt[2:0]`.
- The step function is identical to `adjust_shift`:
  - each of the three BCD nibbles that is >4 gets +3;
  - the whole 20-bit word is then shifted left 1, with a 0 filled in at bit 0.
  - Instantiating `adjust_shift` is required; it is not re-coded.
- FSM states: IDLE, SHIFT.
  - IDLE:
    - If `start`=1: load `work`={12'd0,`bin`}, set `cnt`=0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT:
    - Each cycle: `work` <= step(`work`), `cnt` <= `cnt`+1.
    - When `cnt`==7: `bcd` <= step(`work`)[19:8], pulse `done`, update `blank`, return to IDLE.
- `start` while in SHIFT is ignored; it is not queued.
- `bin` changes during SHIFT have no effect.
- Every nibble of `bcd` is always ≤9. The maximum result is 12'h255.
- Outputs after reset:
  - `busy`=0, `done`=0, `bcd`=12'h000, `blank`=3'b000.
  - State is IDLE; `work` and `cnt` are 0.

## Timing
- `start` is accepted at edge E0. `busy`=1 is visible from E0 through E8.
- The eight step edges are E1…E8. At E8: `bcd`/`blank` are updated, `done`=1, `busy`=0.
- `done` is high for exactly the one cycle following E8.
- Latency: 8 clocks from the accepting edge to `done`.
- Back-to-back: `start` held high in the `done` cycle is accepted at E9, giving 1 result per 9 clocks.
- Reset mid-conversion: reset asserted at any edge aborts the operation.
  - Outputs take their reset values on that edge.
  - No `done` pulse is produced.
  - `bcd` reads 12'h000, not the partial value.
- `rst_n`=0 together with `start`=1: reset wins; the start is not accepted.

## Configuration
- `BIN2BCD_BLANK_EN`:
  - Defined: at completion `blank` is registered as follows.
    - `blank[2]` = (hundreds==0).
    - `blank[1]` = (hundreds==0 && tens==0).
    - `blank[0]` = 0, so the units digit is always shown.
  - Not defined: `blank` is tied to 3'b000. The port still exists, so instantiations are unchanged.

## Test plan
- Reset released, `start` with `bin`=8'd255 → `done` exactly 8 clocks after the accepting edge, `bcd`=12'h255, `busy` high for 8 cycles.
- `bin`=8'd0 → `bcd`=12'h000. With `BIN2BCD_BLANK_EN`, `blank`=3'b110; without it, 3'b000.
- `bin`=8'd99, then `start` held high through `done` with `bin`=8'd100 → first `bcd`=12'h099 (`blank`=3'b100 if enabled), second `bcd`=12'h100 nine clocks after the first `done`.
- `start` pulsed with `bin`=8'd7 at cycle 3 of a conversion of 8'd128 → only one `done`, `bcd`=12'h128, no second conversion.
- `rst_n` low at cycle 5 of a conversion of 8'd200 → on that edge `busy`=0 and `bcd`=12'h000, and no `done` follows.
- Exhaustive sweep of `bin` 0…255 → each `bcd` equals the decimal value, with every nibble ≤9.
